// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_port
// Purpose  : Dual-read, single-write register file whose read side latches
//            two operands (the A/B operand registers of a multicycle
//            datapath). Register 0 reads as zero. A write and a read of the
//            same address in one cycle are bypassed, so the latched operand
//            carries the data being written.
// Ports    : clk      - rising-edge clock
//            reset    - asynchronous, active-high reset
//            we       - write enable
//            waddr    - write address
//            wdata    - write data
//            rd_req   - read request; the addresses are sampled on this edge
//            raddr_a  - read address, port A
//            raddr_b  - read address, port B
//            rdata_a  - latched operand A, held until the next request
//            rdata_b  - latched operand B, held until the next request
//            rd_valid - one-cycle pulse: the operands were updated on this edge
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_port #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_a,
   output logic [WIDTH-1:0]  rdata_b,
   output logic              rd_valid
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] val_a;
   logic [WIDTH-1:0] val_b;
   logic             wr_live;

   // A write to address 0 is treated as no write at all. This makes both
   // the store and the bypass ignore it.
   assign wr_live = we && (waddr != '0);

   // Storage. Entry 0 is reset to zero and never written. The read muxes
   // also force zero for address 0 regardless of the storage contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_live) begin
         mem[waddr] <= wdata;
      end
   end

   // Per-port operand selection. The bypass comes first, then zero for
   // address 0, then the array.
   always_comb begin
      val_a = mem[raddr_a];
      if (wr_live && (waddr == raddr_a)) begin
         val_a = wdata;
      end else if (raddr_a == '0) begin
         val_a = '0;
      end
   end

   always_comb begin
      val_b = mem[raddr_b];
      if (wr_live && (waddr == raddr_b)) begin
         val_b = wdata;
      end else if (raddr_b == '0) begin
         val_b = '0;
      end
   end

   // Operand latches. They load only on a request, so a later write to the
   // source register does not disturb an operand that has already been captured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_a  <= '0;
         rdata_b  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) begin
            rdata_a <= val_a;
            rdata_b <= val_b;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_port
// Purpose  : Self-checking bench for regfile_read_port. Each table row is
//            one clock cycle of stimulus, paired with the outputs expected
//            after that edge. A behavioural model also fills a queue of
//            expected operands, and an entry is popped and compared each time
//            the DUT pulses rd_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_port;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        rd_req;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic        exp_v;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
   } pair_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        rd_req;
   logic [4:0]  raddr_a;
   logic [4:0]  raddr_b;
   logic [31:0] rdata_a;
   logic [31:0] rdata_b;
   logic        rd_valid;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_mem [DEPTH];
   pair_t       sb_q [$];
   logic [31:0] held_a;
   logic [31:0] held_b;
   logic        pend_v;

   vec_t tbl [22];

   regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .rd_req   (rd_req),
      .raddr_a  (raddr_a),
      .raddr_b  (raddr_b),
      .rdata_a  (rdata_a),
      .rdata_b  (rdata_b),
      .rd_valid (rd_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic r, input logic [4:0] a, input logic [4:0] b,
                               input logic [31:0] ea, input logic [31:0] eb, input logic ev);
      vec_t v;
      v.we = w; v.waddr = wa; v.wdata = wd; v.rd_req = r; v.ra = a; v.rb = b;
      v.exp_a = ea; v.exp_b = eb; v.exp_v = ev;
      return v;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] ra, input logic w,
                                              input logic [4:0] wa, input logic [31:0] wd);
      if (w && wa == ra && ra != 5'd0) return wd;
      if (ra == 5'd0) return 32'd0;
      return model_mem[ra];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
      sb_q.delete();
      held_a = 32'd0;
      held_b = 32'd0;
      pend_v = 1'b0;
   endtask

   // Runs one clock cycle. Stimulus is driven after the falling edge and
   // the outputs are sampled 1 ns after the rising edge. When use_tbl is
   // set, the outputs are also compared with the row's constant expectations.
   task automatic step(input vec_t v, input bit use_tbl, input string tag);
      pair_t p;
      @(negedge clk);
      we = v.we; waddr = v.waddr; wdata = v.wdata;
      rd_req = v.rd_req; raddr_a = v.ra; raddr_b = v.rb;
      if (v.rd_req) begin
         p.a = model_read(v.ra, v.we, v.waddr, v.wdata);
         p.b = model_read(v.rb, v.we, v.waddr, v.wdata);
         sb_q.push_back(p);
      end
      if (v.we && v.waddr != 5'd0) model_mem[v.waddr] = v.wdata;
      pend_v = v.rd_req;
      @(posedge clk);
      #1;
      chk({tag, " rd_valid"}, {31'd0, rd_valid}, {31'd0, pend_v});
      if (rd_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk({tag, " unexpected rd_valid"}, 32'd1, 32'd0);
         end else begin
            p = sb_q.pop_front();
            held_a = p.a;
            held_b = p.b;
         end
      end
      chk({tag, " rdata_a"}, rdata_a, held_a);
      chk({tag, " rdata_b"}, rdata_b, held_b);
      if (use_tbl) begin
         chk({tag, " tbl rdata_a"}, rdata_a, v.exp_a);
         chk({tag, " tbl rdata_b"}, rdata_b, v.exp_b);
         chk({tag, " tbl rd_valid"}, {31'd0, rd_valid}, {31'd0, v.exp_v});
      end
   endtask

   initial begin
      // Each row is one cycle: we, waddr, wdata, rd_req, ra, rb, then the
      // expected rdata_a, rdata_b and rd_valid after that edge.
      tbl[0]  = mk(0, 0,  0,            1, 7,  7,  0,            0,            1); // read reg 7 after reset
      tbl[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,  0,            0,            0);
      tbl[2]  = mk(0, 0,  0,            0, 0,  0,  0,            0,            0);
      tbl[3]  = mk(0, 0,  0,            1, 5,  0,  32'hDEADBEEF, 0,            1);
      tbl[4]  = mk(0, 0,  0,            0, 0,  0,  32'hDEADBEEF, 0,            0); // single pulse
      tbl[5]  = mk(1, 12, 32'h12345678, 1, 12, 12, 32'h12345678, 32'h12345678, 1); // bypass
      tbl[6]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,  0,  32'h12345678, 32'h12345678, 0);
      tbl[7]  = mk(0, 0,  0,            1, 0,  5,  0,            32'hDEADBEEF, 1);
      tbl[8]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  12, 0,            32'h12345678, 1); // bypass on r0
      tbl[9]  = mk(1, 3,  32'hA,        0, 0,  0,  0,            32'h12345678, 0);
      tbl[10] = mk(0, 0,  0,            1, 3,  3,  32'hA,        32'hA,        1);
      tbl[11] = mk(1, 3,  32'hB,        0, 3,  3,  32'hA,        32'hA,        0); // hold
      tbl[12] = mk(0, 0,  0,            0, 3,  3,  32'hA,        32'hA,        0);
      tbl[13] = mk(1, 1,  32'd1,        0, 0,  0,  32'hA,        32'hA,        0);
      tbl[14] = mk(1, 2,  32'd2,        0, 0,  0,  32'hA,        32'hA,        0);
      tbl[15] = mk(1, 3,  32'd3,        0, 0,  0,  32'hA,        32'hA,        0);
      tbl[16] = mk(1, 4,  32'd4,        0, 0,  0,  32'hA,        32'hA,        0);
      tbl[17] = mk(0, 0,  0,            1, 1,  4,  32'd1,        32'd4,        1); // streaming
      tbl[18] = mk(0, 0,  0,            1, 2,  3,  32'd2,        32'd3,        1);
      tbl[19] = mk(0, 0,  0,            1, 3,  2,  32'd3,        32'd2,        1);
      tbl[20] = mk(0, 0,  0,            1, 4,  1,  32'd4,        32'd1,        1);
      tbl[21] = mk(0, 0,  0,            0, 0,  0,  32'd4,        32'd1,        0);

      // Reset is held with an active request and random addresses.
      reset = 1'b1;
      we = 1'b1; waddr = 5'd9; wdata = 32'h5555AAAA;
      rd_req = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         raddr_a = 5'($urandom_range(0, 31));
         raddr_b = 5'($urandom_range(0, 31));
         @(posedge clk);
         #1;
         chk("reset rdata_a", rdata_a, 32'd0);
         chk("reset rdata_b", rdata_b, 32'd0);
         chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      we = 1'b0; rd_req = 1'b0;

      for (int i = 0; i < 22; i++) begin
         step(tbl[i], 1'b1, $sformatf("vec%0d", i));
      end

      // Random traffic, checked against the model and scoreboard only.
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                0, 0, 0);
         if (i % 5 == 0) v.ra = v.waddr;
         step(v, 1'b0, $sformatf("rnd%0d", i));
      end

      // Reset during a read: the request is sampled at edge N, and reset is
      // pulsed before edge N+1.
      step(mk(1, 9, 32'h99, 0, 0, 0, 0, 0, 0), 1'b0, "mid wr");
      step(mk(0, 0, 0, 1, 9, 9, 0, 0, 0), 1'b0, "mid rd");
      #2;
      reset = 1'b1;
      #1;
      chk("mid reset rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("mid reset rdata_a", rdata_a, 32'd0);
      chk("mid reset rdata_b", rdata_b, 32'd0);
      rd_req = 1'b0; we = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, "post rst idle");
      step(mk(0, 0, 0, 1, 9, 5, 0, 0, 1), 1'b1, "post rst rd9");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, "post rst end");

      chk("scoreboard drained", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
